// File: rtl/credit_rr_arbiter.sv
// Round-robin arbiter that shares one credit-flow-controlled buffer between
// N_REQ valid/ready requesters. One single-beat transfer per cycle while credits remain.
module credit_rr_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned D_WIDTH      = 6,
  parameter int unsigned CREDIT_WIDTH = 3,
  parameter int unsigned MAX_CREDITS  = 4,
  localparam int unsigned SRC_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           up_valid,
  output logic [N_REQ-1:0]           up_ready,
  input  logic [N_REQ*D_WIDTH-1:0]   up_data,
  output logic                       down_valid,
  output logic [D_WIDTH-1:0]         down_data,
  output logic [SRC_W-1:0]           down_src,
  input  logic                       credit_return,
  output logic [CREDIT_WIDTH-1:0]    credit_cnt,
  output logic                       credit_err
);

  localparam logic [CREDIT_WIDTH-1:0] CreditMax = CREDIT_WIDTH'(MAX_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] CreditOne = CREDIT_WIDTH'(1);
  localparam logic [SRC_W-1:0]        LastInit  = SRC_W'(N_REQ - 1);

  logic [CREDIT_WIDTH-1:0] r_credit_cnt;
  logic                    r_credit_err;
  logic [SRC_W-1:0]        r_last_grant;
  logic                    r_down_valid;
  logic [D_WIDTH-1:0]      r_down_data;
  logic [SRC_W-1:0]        r_down_src;

  logic                    w_issue;
  logic                    w_found;
  logic [SRC_W-1:0]        w_winner;
  logic [D_WIDTH-1:0]      w_win_data;

  // Issue eligibility looks at the registered count only, so a same-cycle
  // credit_return never reaches up_ready combinationally.
  assign w_issue = (r_credit_cnt != '0) && (up_valid != '0);

  // Round-robin search: first pass above the last grant, second pass wraps to 0.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!w_found && (SRC_W'(i) > r_last_grant) && up_valid[i]) begin
        w_found  = 1'b1;
        w_winner = SRC_W'(i);
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!w_found && up_valid[i]) begin
        w_found  = 1'b1;
        w_winner = SRC_W'(i);
      end
    end
  end

  // Select the winner's data slice and drive the one-hot ready.
  always_comb begin
    w_win_data = '0;
    up_ready   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_winner == SRC_W'(i)) begin
        w_win_data  = up_data[i*D_WIDTH +: D_WIDTH];
        up_ready[i] = w_issue & rst;
      end
    end
  end

  // Grant pointer, registered beat output and credit accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit_cnt <= CreditMax;
      r_credit_err <= 1'b0;
      r_last_grant <= LastInit;
      r_down_valid <= 1'b0;
      r_down_data  <= '0;
      r_down_src   <= '0;
    end else begin
      r_down_valid <= w_issue;
      if (w_issue) begin
        r_down_data  <= w_win_data;
        r_down_src   <= w_winner;
        r_last_grant <= w_winner;
      end
      case ({w_issue, credit_return})
        2'b10: r_credit_cnt <= r_credit_cnt - CreditOne;
        2'b01: begin
          // A return with a full counter means the buffer returned more than it got.
          if (r_credit_cnt == CreditMax) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credit_cnt <= r_credit_cnt + CreditOne;
          end
        end
        default: ;
      endcase
    end
  end

  assign down_valid = r_down_valid;
  assign down_data  = r_down_data;
  assign down_src   = r_down_src;
  assign credit_cnt = r_credit_cnt;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_credit_rr_arbiter.sv
// Self-checking bench for credit_rr_arbiter: a cycle model predicts grants and
// credits, and a scoreboard queue matches predicted beats against down_* outputs.
module tb_credit_rr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 6;
  localparam int CW  = 3;
  localparam int MAX = 4;
  localparam int SW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    up_valid;
  logic [N-1:0]    up_ready;
  logic [N*DW-1:0] up_data;
  logic            down_valid;
  logic [DW-1:0]   down_data;
  logic [SW-1:0]   down_src;
  logic            credit_return;
  logic [CW-1:0]   credit_cnt;
  logic            credit_err;

  credit_rr_arbiter #(
    .N_REQ       (N),
    .D_WIDTH     (DW),
    .CREDIT_WIDTH(CW),
    .MAX_CREDITS (MAX)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .up_valid     (up_valid),
    .up_ready     (up_ready),
    .up_data      (up_data),
    .down_valid   (down_valid),
    .down_data    (down_data),
    .down_src     (down_src),
    .credit_return(credit_return),
    .credit_cnt   (credit_cnt),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    cap_q[$];
  bit    cap_en = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;
  int    n_beats = 0;

  // Model state
  int    m_cnt;
  int    m_last;
  bit    m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  // Cycle model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      m_cnt  = MAX;
      m_last = N - 1;
      m_err  = 1'b0;
      exp_q.delete();
      check_eq("rst_down_valid", 32'(down_valid), 32'd0);
      check_eq("rst_up_ready", 32'(up_ready), 32'd0);
      check_eq("rst_credit_cnt", 32'(credit_cnt), 32'(MAX));
    end else begin
      bit           exp_dv;
      bit           issue;
      int           win;
      logic [N-1:0] exp_rdy;
      exp_dv = (exp_q.size() != 0);
      check_eq("down_valid", 32'(down_valid), 32'(exp_dv));
      if (exp_dv && down_valid) begin
        beat_t b;
        b = exp_q.pop_front();
        check_eq("down_src", 32'(down_src), 32'(b.src));
        check_eq("down_data", 32'(down_data), 32'(b.data));
        n_beats++;
        if (cap_en) cap_q.push_back(int'(down_src));
      end
      issue   = (m_cnt != 0) && (up_valid != '0);
      win     = rr_pick(m_last, up_valid);
      exp_rdy = issue ? (N'(1) << win) : '0;
      check_eq("up_ready", 32'(up_ready), 32'(exp_rdy));
      check_eq("credit_cnt", 32'(credit_cnt), 32'(m_cnt));
      check_eq("credit_err", 32'(credit_err), 32'(m_err));
      if (issue) begin
        beat_t nb;
        nb.src  = win;
        nb.data = up_data[win*DW +: DW];
        exp_q.push_back(nb);
        m_last = win;
      end
      if (issue && !credit_return) m_cnt--;
      else if (!issue && credit_return) begin
        if (m_cnt == MAX) m_err = 1'b1;
        else m_cnt++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    up_valid      = '0;
    credit_return = 1'b0;
    cycles(2);
    rst = 1'b1;
  endtask

  initial begin
    int beats0;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    rst           = 1'b0;
    up_valid      = '0;
    up_data       = '0;
    credit_return = 1'b0;
    cycles(3);
    rst = 1'b1;

    // Idle after reset
    cycles(10);
    @(negedge clk);
    check_eq("idle_cnt", 32'(credit_cnt), 32'd4);
    check_eq("idle_ready", 32'(up_ready), 32'd0);

    // Sole requester 2 drains all credits
    cycles(1);
    up_data[2*DW +: DW] = 6'h15;
    up_valid = 4'b0100;
    beats0 = n_beats;
    cycles(8);
    @(negedge clk);
    check_eq("solo_cnt_empty", 32'(credit_cnt), 32'd0);
    check_eq("solo_ready_off", 32'(up_ready), 32'd0);
    check_eq("solo_beats", 32'(n_beats - beats0), 32'd4);

    // All four requesters, return every cycle after the first issue
    do_reset();
    for (int i = 0; i < N; i++) up_data[i*DW +: DW] = DW'(8'h10 + i);
    cap_en   = 1'b1;
    up_valid = 4'b1111;
    cycles(1);
    credit_return = 1'b1;
    cycles(5);
    up_valid      = '0;
    credit_return = 1'b0;
    cycles(2);
    cap_en = 1'b0;
    @(negedge clk);
    check_eq("rr_cnt_settle", 32'(credit_cnt), 32'd3);
    check_eq("rr_beat_count", 32'(cap_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < cap_q.size(); i++)
      check_eq("rr_order", 32'(cap_q[i]), 32'(exp_order[i]));

    // Credit return at zero re-enables exactly one grant
    do_reset();
    up_valid = 4'b0010;
    cycles(6);
    @(negedge clk);
    check_eq("drain_cnt", 32'(credit_cnt), 32'd0);
    cycles(1);
    credit_return = 1'b1;
    cycles(1);
    credit_return = 1'b0;
    @(negedge clk);
    check_eq("ret_cnt_one", 32'(credit_cnt), 32'd1);
    check_eq("ret_ready", 32'(up_ready), 32'b0010);
    @(negedge clk);
    check_eq("ret_cnt_zero", 32'(credit_cnt), 32'd0);
    check_eq("ret_dv", 32'(down_valid), 32'd1);
    check_eq("ret_src", 32'(down_src), 32'd1);
    cycles(1);
    up_valid = '0;

    // Overflow sets the sticky error
    do_reset();
    cycles(1);
    credit_return = 1'b1;
    cycles(1);
    credit_return = 1'b0;
    @(negedge clk);
    check_eq("ovf_err", 32'(credit_err), 32'd1);
    check_eq("ovf_cnt", 32'(credit_cnt), 32'd4);
    cycles(4);
    @(negedge clk);
    check_eq("ovf_sticky", 32'(credit_err), 32'd1);
    do_reset();
    @(negedge clk);
    check_eq("ovf_cleared", 32'(credit_err), 32'd0);

    // Mid-stream asynchronous reset
    cycles(1);
    up_data[0*DW +: DW] = 6'h2a;
    up_data[3*DW +: DW] = 6'h31;
    up_valid = 4'b1001;
    cycles(1);
    credit_return = 1'b1;
    cycles(4);
    @(posedge clk);
    #3;
    rst           = 1'b0;
    credit_return = 1'b0;
    #1;
    check_eq("async_dv", 32'(down_valid), 32'd0);
    check_eq("async_cnt", 32'(credit_cnt), 32'd4);
    check_eq("async_ready", 32'(up_ready), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_grant", 32'(up_ready), 32'b0001);
    cycles(2);
    up_valid = '0;
    cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
